// File: rtl/RV32i_pkg.sv
// Shared types for the RV32I instruction/data memory arbiter.
package RV32i_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_t;

    // Transaction captured in IDLE and held until completion
    typedef struct packed {
        arb_owner_t        owner;
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [BE_W-1:0]   be;
    } arb_txn_t;

endpackage

// File: rtl/rv32i_mem_arbiter.sv
// Shares one memory port between instruction fetch and MEM-stage data accesses.
// Optional macro RV32I_ARB_RR_EN selects round-robin arbitration instead of data-first.
module rv32i_mem_arbiter (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_valid_o,
    output logic        stall_fetch_o,
    input  logic        dmem_re_i,
    input  logic        dmem_we_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    input  logic [3:0]  dmem_be_i,
    output logic [31:0] dmem_rdata_o,
    output logic        stall_exec_o,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);
    import RV32i_pkg::*;

    arb_state_t state_q, state_d;
    arb_txn_t   txn_q, txn_d;
    logic       discard_q, discard_d;
    logic       data_pend_c;
    logic       pick_data_c;
    logic       done_c;
    logic       data_done_c;
    logic       fetch_done_c;

    assign data_pend_c = dmem_re_i | dmem_we_i;

`ifdef RV32I_ARB_RR_EN
    arb_owner_t last_q, last_d;
    // On a tie the owner of the previous grant yields
    assign pick_data_c = data_pend_c & (~if_req_i | (last_q == OWN_FETCH));
`else
    assign pick_data_c = data_pend_c;
`endif

    // Next-state and latch-field logic
    always_comb begin
        state_d   = state_q;
        txn_d     = txn_q;
        discard_d = discard_q;
        done_c    = 1'b0;
`ifdef RV32I_ARB_RR_EN
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (data_pend_c || if_req_i) begin
                    state_d = REQ;
                    if (pick_data_c) begin
                        txn_d = '{owner: OWN_DATA, we: dmem_we_i, addr: dmem_addr_i,
                                  wdata: dmem_wdata_i, be: dmem_be_i};
                    end else begin
                        txn_d = '{owner: OWN_FETCH, we: 1'b0, addr: if_addr_i,
                                  wdata: '0, be: 4'hF};
                    end
`ifdef RV32I_ARB_RR_EN
                    last_d = pick_data_c ? OWN_DATA : OWN_FETCH;
`endif
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    if (txn_q.we) begin
                        done_c  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (mem_rvalid_i) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fetch made obsolete by a taken branch still drains on the bus
        if (state_q != IDLE && txn_q.owner == OWN_FETCH && flush_i) begin
            discard_d = 1'b1;
        end
        if (done_c) begin
            discard_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            txn_q     <= '0;
            discard_q <= 1'b0;
`ifdef RV32I_ARB_RR_EN
            last_q    <= OWN_FETCH;
`endif
        end else begin
            txn_q     <= txn_d;
            discard_q <= discard_d;
`ifdef RV32I_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    assign data_done_c  = done_c & (txn_q.owner == OWN_DATA);
    assign fetch_done_c = done_c & (txn_q.owner == OWN_FETCH);

    assign mem_req_o    = (state_q == REQ);
    assign mem_we_o     = txn_q.we;
    assign mem_addr_o   = txn_q.addr;
    assign mem_wdata_o  = txn_q.wdata;
    assign mem_be_o     = txn_q.be;

    assign if_valid_o    = fetch_done_c & ~discard_q & ~flush_i;
    assign if_rdata_o    = if_valid_o ? mem_rdata_i : '0;
    assign dmem_rdata_o  = (data_done_c && !txn_q.we) ? mem_rdata_i : '0;
    assign stall_exec_o  = data_pend_c & ~data_done_c;
    assign stall_fetch_o = if_req_i & ~if_valid_o;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench for rv32i_mem_arbiter: directed vector table, reset and
// arbitration sequences, then random traffic against a transaction-level model.
module tb_rv32i_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        resetn_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_valid_o;
    logic        stall_fetch_o;
    logic        dmem_re_i;
    logic        dmem_we_i;
    logic [31:0] dmem_addr_i;
    logic [31:0] dmem_wdata_i;
    logic [3:0]  dmem_be_i;
    logic [31:0] dmem_rdata_o;
    logic        stall_exec_o;
    logic        flush_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    always #5 clk_i = ~clk_i;

    rv32i_mem_arbiter dut (
        .clk_i         (clk_i),
        .resetn_i      (resetn_i),
        .if_req_i      (if_req_i),
        .if_addr_i     (if_addr_i),
        .if_rdata_o    (if_rdata_o),
        .if_valid_o    (if_valid_o),
        .stall_fetch_o (stall_fetch_o),
        .dmem_re_i     (dmem_re_i),
        .dmem_we_i     (dmem_we_i),
        .dmem_addr_i   (dmem_addr_i),
        .dmem_wdata_i  (dmem_wdata_i),
        .dmem_be_i     (dmem_be_i),
        .dmem_rdata_o  (dmem_rdata_o),
        .stall_exec_o  (stall_exec_o),
        .flush_i       (flush_i),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_be_o      (mem_be_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    typedef struct {
        logic [31:0] rst, if_req, if_addr, re, we, daddr, wdata, be, gnt, rvalid, flush, rdata;
        logic [31:0] e_mreq, e_mwe, e_maddr, e_mwd, e_mbe, e_ifv, e_ifrd, e_dchk, e_drd, e_sf, e_se;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(
        input logic [31:0] rst, ifr, ifa, re, we, da, wd, be, g, rv, fl, rd,
        input logic [31:0] mreq, mwe, maddr, mwd, mbe, ifv, ifrd, dchk, drd, sf, se);
        vec_t v;
        v = '{rst, ifr, ifa, re, we, da, wd, be, g, rv, fl, rd,
              mreq, mwe, maddr, mwd, mbe, ifv, ifrd, dchk, drd, sf, se};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag,
        input logic [31:0] mreq, mwe, maddr, mwd, mbe, ifv, ifrd, dchk, drd, sf, se);
        chk({tag, ".mem_req"}, 32'(mem_req_o), mreq);
        if (mreq[0]) begin
            chk({tag, ".mem_addr"}, mem_addr_o, maddr);
            chk({tag, ".mem_we"}, 32'(mem_we_o), mwe);
            if (mwe[0]) begin
                chk({tag, ".mem_wdata"}, mem_wdata_o, mwd);
                chk({tag, ".mem_be"}, 32'(mem_be_o), mbe);
            end
        end
        chk({tag, ".if_valid"}, 32'(if_valid_o), ifv);
        if (ifv[0]) chk({tag, ".if_rdata"}, if_rdata_o, ifrd);
        if (dchk[0]) chk({tag, ".dmem_rdata"}, dmem_rdata_o, drd);
        chk({tag, ".stall_fetch"}, 32'(stall_fetch_o), sf);
        chk({tag, ".stall_exec"}, 32'(stall_exec_o), se);
    endtask

    task automatic clear_inputs;
        if_req_i = 0; if_addr_i = 0; dmem_re_i = 0; dmem_we_i = 0;
        dmem_addr_i = 0; dmem_wdata_i = 0; dmem_be_i = 0; flush_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    endtask

    task automatic do_reset;
        @(negedge clk_i);
        resetn_i = 1'b0;
        clear_inputs();
        @(negedge clk_i);
        resetn_i = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Model state for the random phase: one transaction record in flight
    logic        m_busy, m_gnted, m_disc, m_own_data, m_we, m_last_data;
    logic [31:0] m_addr, m_wd;
    logic [3:0]  m_be;

    initial begin
        logic exp_own[4];
        logic got_own[4];
        int   n;

        resetn_i = 1'b0;
        clear_inputs();

        // rst ifr ifa re we da wd be g rv fl rd | mreq mwe maddr mwd mbe ifv ifrd dchk drd sf se
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,              0,0,0,0,0,0,0,0,0,0,0));
        // fetch 0x100, immediate grant, rvalid next
        vecs.push_back(mk(0,1,'h100,0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0,0,0,0,1,0));
        vecs.push_back(mk(0,1,'h100,0,0,0,0,0,1,0,0,0,          1,0,'h100,0,0,0,0,0,0,1,0));
        vecs.push_back(mk(0,1,'h100,0,0,0,0,0,0,1,0,'h13,       0,0,0,0,0,1,'h13,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,              0,0,0,0,0,0,0,0,0,0,0));
        // simultaneous fetch 0x104 and load 0x2000
        vecs.push_back(mk(1,1,'h104,1,0,'h2000,0,0,0,0,0,0,     0,0,0,0,0,0,0,0,0,1,1));
        vecs.push_back(mk(0,1,'h104,1,0,'h2000,0,0,1,0,0,0,     1,0,'h2000,0,0,0,0,0,0,1,1));
        vecs.push_back(mk(0,1,'h104,1,0,'h2000,0,0,0,1,0,'hA5A50001, 0,0,0,0,0,0,0,1,'hA5A50001,1,0));
        vecs.push_back(mk(0,1,'h104,0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0,0,0,0,1,0));
        vecs.push_back(mk(0,1,'h104,0,0,0,0,0,1,0,0,0,          1,0,'h104,0,0,0,0,0,0,1,0));
        vecs.push_back(mk(0,1,'h104,0,0,0,0,0,0,1,0,'h93,       0,0,0,0,0,1,'h93,0,0,0,0));
        // store with grant held low 3 cycles; stray rvalid ignored; no RESP afterwards
        vecs.push_back(mk(1,0,0,0,1,'h2004,'hDEADBEEF,'hF,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,1,'h2004,'hDEADBEEF,'hF,0,0,0,0, 1,1,'h2004,'hDEADBEEF,'hF,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,1,'h2004,'hDEADBEEF,'hF,0,1,0,0, 1,1,'h2004,'hDEADBEEF,'hF,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,1,'h2004,'hDEADBEEF,'hF,0,0,0,0, 1,1,'h2004,'hDEADBEEF,'hF,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,1,'h2004,'hDEADBEEF,'hF,1,0,0,0, 1,1,'h2004,'hDEADBEEF,'hF,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,'h500,0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0,0,0,0,1,0));
        vecs.push_back(mk(0,1,'h500,0,0,0,0,0,1,0,0,0,          1,0,'h500,0,0,0,0,0,0,1,0));
        vecs.push_back(mk(0,1,'h500,0,0,0,0,0,0,1,0,'h13,       0,0,0,0,0,1,'h13,0,0,0,0));
        // flush during fetch RESP, then refetch at new address with slow grant
        vecs.push_back(mk(1,1,'h200,0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0,0,0,0,1,0));
        vecs.push_back(mk(0,1,'h200,0,0,0,0,0,1,0,0,0,          1,0,'h200,0,0,0,0,0,0,1,0));
        vecs.push_back(mk(0,1,'h200,0,0,0,0,0,0,0,1,0,          0,0,0,0,0,0,0,0,0,1,0));
        vecs.push_back(mk(0,1,'h300,0,0,0,0,0,0,1,0,'h13,       0,0,0,0,0,0,0,0,0,1,0));
        vecs.push_back(mk(0,1,'h300,0,0,0,0,0,0,0,0,0,          0,0,0,0,0,0,0,0,0,1,0));
        vecs.push_back(mk(0,1,'h300,0,0,0,0,0,0,0,0,0,          1,0,'h300,0,0,0,0,0,0,1,0));
        vecs.push_back(mk(0,1,'h300,0,0,0,0,0,0,0,0,0,          1,0,'h300,0,0,0,0,0,0,1,0));
        vecs.push_back(mk(0,1,'h300,0,0,0,0,0,1,0,0,0,          1,0,'h300,0,0,0,0,0,0,1,0));
        vecs.push_back(mk(0,1,'h300,0,0,0,0,0,0,1,0,'h33,       0,0,0,0,0,1,'h33,0,0,0,0));

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            if (v.rst[0]) do_reset();
            @(negedge clk_i);
            if_req_i     = v.if_req[0];
            if_addr_i    = v.if_addr;
            dmem_re_i    = v.re[0];
            dmem_we_i    = v.we[0];
            dmem_addr_i  = v.daddr;
            dmem_wdata_i = v.wdata;
            dmem_be_i    = v.be[3:0];
            mem_gnt_i    = v.gnt[0];
            mem_rvalid_i = v.rvalid[0];
            flush_i      = v.flush[0];
            mem_rdata_i  = v.rdata;
            #1;
            chk_outs($sformatf("vec%0d", i), v.e_mreq, v.e_mwe, v.e_maddr, v.e_mwd, v.e_mbe,
                     v.e_ifv, v.e_ifrd, v.e_dchk, v.e_drd, v.e_sf, v.e_se);
        end

        // reset clears latched fields; reset in REQ abandons the store
        do_reset();
        #1;
        chk("rst.mem_addr", mem_addr_o, 32'h0);
        chk("rst.mem_we", 32'(mem_we_o), 32'h0);
        chk("rst.mem_be", 32'(mem_be_o), 32'h0);
        @(negedge clk_i);
        dmem_we_i = 1; dmem_addr_i = 32'h40; dmem_wdata_i = 32'h1; dmem_be_i = 4'h3;
        @(negedge clk_i);
        #1;
        chk("rstreq.pre_req", 32'(mem_req_o), 32'h1);
        resetn_i = 1'b0;
        #1;
        chk("rstreq.mem_req", 32'(mem_req_o), 32'h0);
        chk("rstreq.stall_exec", 32'(stall_exec_o), 32'h1);
        chk("rstreq.mem_addr", mem_addr_o, 32'h0);
        @(negedge clk_i);
        resetn_i = 1'b1;
        dmem_we_i = 0;
        mem_gnt_i = 1;
        @(negedge clk_i);
        #1;
        chk("rstreq.idle_req", 32'(mem_req_o), 32'h0);
        chk("rstreq.idle_stall", 32'(stall_exec_o), 32'h0);

        // reset while a fetch waits in RESP: late rvalid gives no completion
        do_reset();
        @(negedge clk_i);
        if_req_i = 1; if_addr_i = 32'h80; mem_gnt_i = 1;
        @(negedge clk_i);
        @(negedge clk_i);
        mem_gnt_i = 0;
        resetn_i = 1'b0;
        @(negedge clk_i);
        resetn_i = 1'b1;
        mem_rvalid_i = 1; mem_rdata_i = 32'hBAD;
        #1;
        chk("rstresp.if_valid", 32'(if_valid_o), 32'h0);
        chk("rstresp.stall_fetch", 32'(stall_fetch_o), 32'h1);

        // continuous fetch + load: grant order depends on arbitration mode
`ifdef RV32I_ARB_RR_EN
        exp_own = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_own = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        do_reset();
        @(negedge clk_i);
        if_req_i = 1; if_addr_i = 32'h104; dmem_re_i = 1; dmem_addr_i = 32'h2000;
        mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h7;
        n = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk_i);
            #1;
            if (mem_req_o && n < 4) begin
                got_own[n] = (mem_addr_o == 32'h2000);
                n++;
            end
        end
        chk("arb.grant_count", 32'(n >= 4), 32'h1);
        for (int k = 0; k < 4; k++) begin
            if (k < n) chk($sformatf("arb.owner%0d", k), 32'(got_own[k]), 32'(exp_own[k]));
        end

        // random traffic against the transaction model
        do_reset();
        m_busy = 0; m_gnted = 0; m_disc = 0; m_own_data = 0; m_we = 0;
        m_addr = 0; m_wd = 0; m_be = 0; m_last_data = 0;
        for (int i = 0; i < 3000; i++) begin
            logic d_pend, f_pend, e_mreq, done, ddone, fdone, e_ifv, pick_d;
            @(negedge clk_i);
            if_req_i     = ($urandom_range(0, 9) < 6);
            if_addr_i    = $urandom;
            dmem_re_i    = ($urandom_range(0, 9) < 4);
            dmem_we_i    = ($urandom_range(0, 9) < 3);
            dmem_addr_i  = $urandom;
            dmem_wdata_i = $urandom;
            dmem_be_i    = 4'($urandom);
            mem_gnt_i    = ($urandom_range(0, 1) == 1);
            mem_rvalid_i = ($urandom_range(0, 1) == 1);
            flush_i      = ($urandom_range(0, 9) == 0);
            mem_rdata_i  = $urandom;
            #1;
            d_pend = dmem_re_i | dmem_we_i;
            f_pend = if_req_i;
            e_mreq = m_busy & ~m_gnted;
            done   = m_busy & (m_gnted ? mem_rvalid_i : (mem_gnt_i & m_we));
            ddone  = done & m_own_data;
            fdone  = done & ~m_own_data;
            e_ifv  = fdone & ~m_disc & ~flush_i;
            chk_outs($sformatf("rnd%0d", i), 32'(e_mreq), 32'(m_we), m_addr, m_wd, 32'(m_be),
                     32'(e_ifv), mem_rdata_i, 32'(ddone & ~m_we), mem_rdata_i,
                     32'(f_pend & ~e_ifv), 32'(d_pend & ~ddone));
            if (!m_busy) begin
                if (d_pend || f_pend) begin
`ifdef RV32I_ARB_RR_EN
                    pick_d = d_pend && (!f_pend || !m_last_data);
`else
                    pick_d = d_pend;
`endif
                    m_busy = 1; m_gnted = 0; m_last_data = pick_d; m_own_data = pick_d;
                    if (pick_d) begin
                        m_we = dmem_we_i; m_addr = dmem_addr_i; m_wd = dmem_wdata_i; m_be = dmem_be_i;
                    end else begin
                        m_we = 0; m_addr = if_addr_i;
                    end
                end
            end else if (done) begin
                m_busy = 0; m_disc = 0;
            end else begin
                if (flush_i && !m_own_data) m_disc = 1;
                if (mem_gnt_i && !m_gnted) m_gnted = 1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_mem_arbiter.md
RV32I_MEM_ARBITER -- requirements
Module: rv32i_mem_arbiter

Interface
REQ-001 SHALL have ports: clk_i  in  1  clock; all state on rising edge.
REQ-002 SHALL have ports: resetn_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: if_req_i  in  1 fetch request; if_addr_i  in  32 fetch address.
REQ-004 SHALL have ports: if_rdata_o  out  32 fetched word; if_valid_o  out  1 one-cycle fetch completion; stall_fetch_o  out  1 hold PC/fetch stage.
REQ-005 SHALL have ports: dmem_re_i  in  1; dmem_we_i  in  1; dmem_addr_i  in  32; dmem_wdata_i  in  32; dmem_be_i  in  4 (MEM-stage access).
REQ-006 SHALL have ports: dmem_rdata_o  out  32 load data; stall_exec_o  out  1 hold EXEC/MEM stages.
REQ-007 SHALL have ports: flush_i  in  1 branch taken, current fetch obsolete.
REQ-008 SHALL have ports: mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  32; mem_wdata_o  out  32; mem_be_o  out  4; mem_gnt_i  in  1; mem_rvalid_i  in  1; mem_rdata_i  in  32 (single shared memory port).

Function
REQ-009 SHALL implement FSM states IDLE, REQ, RESP; at most one memory transaction outstanding.
REQ-010 IDLE: if a data request (re|we) or fetch request is pending, SHALL latch owner, address, wdata, be, we and go to REQ next cycle; otherwise stay IDLE.
REQ-011 Arbitration SHALL be fixed priority data over fetch when both pending in IDLE.
REQ-012 REQ: mem_req_o=1 with latched fields stable until mem_gnt_i=1; SHALL never deassert mem_req_o before grant.
REQ-013 On grant: write SHALL complete that cycle and return to IDLE; read SHALL go to RESP.
REQ-014 RESP: wait for mem_rvalid_i; on rvalid SHALL complete and return to IDLE; mem_req_o=0 in RESP.
REQ-015 Data completion cycle SHALL drive dmem_rdata_o=mem_rdata_i (combinational pass-through, reads only); fetch completion cycle SHALL drive if_rdata_o=mem_rdata_i and if_valid_o=1.
REQ-016 stall_exec_o SHALL equal (dmem_re_i|dmem_we_i) AND NOT data-completion-this-cycle; stall_fetch_o SHALL equal if_req_i AND NOT valid-fetch-completion-this-cycle.
REQ-017 Minimum latency: write 2 cycles (IDLE latch, REQ with gnt); read 3 cycles (latch, gnt, rvalid).
REQ-018 After a completion the block SHALL return to IDLE and SHALL NOT reissue the completed request; a fresh request is sampled the following cycle.
REQ-019 flush_i while a fetch is latched (REQ or RESP) SHALL set a discard flag: transaction runs to completion on the memory side, if_valid_o stays 0, stall_fetch_o stays 1; flag clears on completion.
REQ-020 flush_i in IDLE or during a data transaction SHALL have no effect on data path.
REQ-021 dmem_re_i and dmem_we_i both high SHALL be treated as a write.
REQ-022 mem_rvalid_i outside RESP SHALL be ignored.

Reset
REQ-023 Reset SHALL force state IDLE, discard flag 0, latched fields 0, mem_req_o=0, if_valid_o=0; stall outputs follow REQ-016 combinationally.
REQ-024 Reset mid-transaction SHALL abandon it without a completion pulse.

Configuration
REQ-025 Macro RV32I_ARB_RR_EN defined: IDLE arbitration SHALL be round-robin (owner of last grant loses ties); undefined: fixed priority of REQ-011.

Structure
REQ-026 arb_state_t (IDLE/REQ/RESP) and arb_owner_t (OWN_FETCH/OWN_DATA) SHALL live in RV32i_pkg.
REQ-027 Single module, no sub-module; one FSM process, one latch register process, combinational output logic.

Verification
REQ-028 Fetch 0x100, gnt immediate, rvalid next, rdata 0x00000013 -> if_valid_o=1 in cycle 3, if_rdata_o=0x00000013, stall_fetch_o low that cycle.
REQ-029 Simultaneous fetch 0x104 and load 0x2000 -> data granted first, dmem_rdata_o=mem_rdata_i, then fetch issued; stall_fetch_o high throughout load.
REQ-030 Store 0x2004 wdata 0xDEADBEEF be 0xF, gnt held low 3 cycles -> mem_req_o/fields stable 3 cycles, stall_exec_o drops in gnt cycle, no RESP.
REQ-031 flush_i during fetch RESP -> no if_valid_o pulse, next fetch issued at new if_addr_i, mem_req_o never dropped pre-grant.
REQ-032 With RV32I_ARB_RR_EN, continuous fetch and load requests -> grants alternate DATA/FETCH.
REQ-033 resetn_i low in REQ -> mem_req_o=0, state IDLE, no completion pulse.
